// File: rtl/memu_split_txn.sv
// ---------------------------------------------------------------------------
// memu_split_txn -- MEM pipeline stage for a split-transaction data SRAM.
//
// Memory instructions whose request was accepted in EXE (req_sent) wait in
// MEM until the matching in-order response (data_ok) arrives. A response can
// be consumed in the very cycle it arrives, or parked in a one-entry buffer
// when WB is back-pressuring. The stage counts accepted-but-unanswered
// requests and, on a WB flush, turns every one still owed into a "cancel"
// credit so late responses to killed instructions are silently dropped.
//
// Ports
//   clk, resetn            clock / asynchronous active-low reset
//   flush                  WB exception/ertn flush (kills MEM and EXE)
//   exe_to_mem_valid/zip   incoming instruction (93-bit bundle)
//   mem_allowin            MEM can take a new instruction this cycle
//   data_sram_req/addr_ok  observed request strobe and its acceptance
//   data_sram_data_ok      one in-order response this cycle
//   data_sram_rdata        response data
//   mem_outstanding_full   outstanding count reached MAX_OUTSTANDING
//   wb_allowin             WB can accept
//   mem_to_wb_valid/zip    instruction toward WB (87-bit bundle)
//   mem_rf_zip             {fwd_stall, fwd_we, rf_waddr, rf_wdata} to ID
// ---------------------------------------------------------------------------
module memu_split_txn #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,

    input  logic        exe_to_mem_valid,
    input  logic [92:0] exe_to_mem_zip,
    output logic        mem_allowin,

    input  logic        data_sram_req,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_outstanding_full,

    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [86:0] mem_to_wb_zip,
    output logic [38:0] mem_rf_zip
);

    // Incoming bundle, MSB first.
    typedef struct packed {
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic [3:0]  mem_op;
        logic [31:0] pc;
        logic        ex_valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        is_ertn;
        logic        req_sent;
    } exe_pkt_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    localparam logic [3:0] OP_LD_B  = 4'd0;
    localparam logic [3:0] OP_LD_H  = 4'd1;
    localparam logic [3:0] OP_LD_W  = 4'd2;
    localparam logic [3:0] OP_LD_BU = 4'd8;
    localparam logic [3:0] OP_LD_HU = 4'd9;

    exe_pkt_t         exe_pkt;
    exe_pkt_t         mem_r;
    logic             mem_valid;

    logic             buf_valid;
    logic [31:0]      buf_data;

    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] out_cnt_nxt;
    logic [CNT_W-1:0] cancel_cnt;

    logic             accept;
    logic             wait_resp;
    logic             resp_here;
    logic             mem_ready_go;
    logic             mem_leave;

    logic [31:0]      src;
    logic [1:0]       offset;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_data;
    logic [31:0]      rf_wdata;
    logic             fwd_we;
    logic             fwd_stall;

    assign exe_pkt = exe_to_mem_zip;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign accept       = data_sram_req & data_sram_addr_ok;
    // Excepting instructions never wait; their response is reclaimed by
    // the flush they raise once they reach WB.
    assign wait_resp    = mem_valid & mem_r.req_sent & ~mem_r.ex_valid;
    // Responses are in order, so while cancel credits remain the response
    // belongs to a killed instruction.
    assign resp_here    = data_sram_data_ok & (cancel_cnt == '0);
    assign mem_ready_go = ~wait_resp | buf_valid | resp_here;
    assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);
    assign mem_leave    = mem_valid & mem_ready_go & wb_allowin;

    assign mem_to_wb_valid      = mem_valid & mem_ready_go & ~flush;
    assign mem_outstanding_full = (out_cnt == MAX_CNT);

    // ------------------------------------------------------------------
    // Stage valid and payload
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (flush) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= exe_to_mem_valid;
        end
    end

    // Payload is qualified by mem_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (exe_to_mem_valid && mem_allowin) begin
            mem_r <= exe_pkt;
        end
    end

    // ------------------------------------------------------------------
    // One-entry response buffer: holds a response that arrived while the
    // waiting instruction could not leave (WB back-pressure), so the bus
    // data may change underneath it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
        end else if (flush || mem_leave) begin
            buf_valid <= 1'b0;
        end else if (resp_here && wait_resp && !buf_valid) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_here && wait_resp && !buf_valid && !mem_leave) begin
            buf_data <= data_sram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding / cancel accounting
    // ------------------------------------------------------------------
    // Accept and data_ok together cancel out. An accept while full is a
    // protocol violation; the count saturates instead of wrapping.
    always_comb begin
        out_cnt_nxt = out_cnt;
        if (accept && !data_sram_data_ok) begin
            if (out_cnt != MAX_CNT) begin
                out_cnt_nxt = out_cnt + ONE;
            end
        end else if (data_sram_data_ok && !accept) begin
            if (out_cnt != '0) begin
                out_cnt_nxt = out_cnt - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_nxt;
        end
    end

    // On flush every response still owed after this cycle belongs to a
    // killed instruction: the MEM one, the EXE one (including a request
    // accepted in the flush cycle itself), and any older cancelled ones.
    // A data_ok in the flush cycle is already removed by out_cnt_nxt, so it
    // is never counted twice.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cancel_cnt <= '0;
        end else if (flush) begin
            cancel_cnt <= out_cnt_nxt;
        end else if (data_sram_data_ok && cancel_cnt != '0) begin
            cancel_cnt <= cancel_cnt - ONE;
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction
    // ------------------------------------------------------------------
    assign src     = buf_valid ? buf_data : data_sram_rdata;
    assign offset  = mem_r.alu_result[1:0];
    assign ld_byte = src[{offset, 3'b000} +: 8];
    assign ld_half = offset[1] ? src[31:16] : src[15:0];

    always_comb begin
        load_data = 32'h0;
        case (mem_r.mem_op)
            OP_LD_B:  load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LD_H:  load_data = {{16{ld_half[15]}}, ld_half};
            OP_LD_W:  load_data = src;
            OP_LD_BU: load_data = {24'h0, ld_byte};
            OP_LD_HU: load_data = {16'h0, ld_half};
            default:  load_data = 32'h0;
        endcase
    end

    assign rf_wdata = mem_r.res_from_mem ? load_data : mem_r.alu_result;

    // ------------------------------------------------------------------
    // Forwarding to ID
    // ------------------------------------------------------------------
    assign fwd_we    = mem_valid & mem_r.rf_we & ~mem_r.ex_valid & ~mem_r.is_ertn;
    // A load still waiting cannot forward yet; ID must stall on it.
    assign fwd_stall = fwd_we & mem_r.res_from_mem & ~mem_ready_go;

    assign mem_rf_zip = {fwd_stall, fwd_we, mem_r.rf_waddr, rf_wdata};

    assign mem_to_wb_zip = {mem_r.rf_we, mem_r.rf_waddr, rf_wdata, mem_r.pc,
                            mem_r.ex_valid, mem_r.ecode, mem_r.esubcode,
                            mem_r.is_ertn};

endmodule

// File: tb/tb_memu_split_txn.sv
module tb_memu_split_txn;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        exe_to_mem_valid;
    logic [92:0] exe_to_mem_zip;
    logic        mem_allowin;
    logic        data_sram_req;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_outstanding_full;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [86:0] mem_to_wb_zip;
    logic [38:0] mem_rf_zip;

    int errors = 0;
    int checks = 0;

    memu_split_txn #(.MAX_OUTSTANDING(2), .CNT_W(3)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .flush                (flush),
        .exe_to_mem_valid     (exe_to_mem_valid),
        .exe_to_mem_zip       (exe_to_mem_zip),
        .mem_allowin          (mem_allowin),
        .data_sram_req        (data_sram_req),
        .data_sram_addr_ok    (data_sram_addr_ok),
        .data_sram_data_ok    (data_sram_data_ok),
        .data_sram_rdata      (data_sram_rdata),
        .mem_outstanding_full (mem_outstanding_full),
        .wb_allowin           (wb_allowin),
        .mem_to_wb_valid      (mem_to_wb_valid),
        .mem_to_wb_zip        (mem_to_wb_zip),
        .mem_rf_zip           (mem_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [3:0]  op;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [92:0] mk_zip(input logic res, input logic [31:0] alu,
                                           input logic [3:0] op, input logic [31:0] pc,
                                           input logic ex, input logic rs);
        return {res, 1'b1, 5'd7, alu, op, pc, ex, 6'd0, 9'd0, 1'b0, rs};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wb_wdata();
        return mem_to_wb_zip[80:49];
    endfunction

    task automatic idle_inputs();
        exe_to_mem_valid  = 1'b0;
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        flush             = 1'b0;
    endtask

    // Issue a load from EXE with an accepted request; it enters MEM on the
    // next posedge. Returns at the following negedge with inputs idle.
    task automatic enter_load(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] pc);
        @(negedge clk);
        exe_to_mem_valid  = 1'b1;
        exe_to_mem_zip    = mk_zip(1'b1, alu, op, pc, 1'b0, 1'b1);
        data_sram_req     = 1'b1;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'd2, 32'h1000_0000, 32'h8765_4321, 32'h8765_4321};
        vecs[1]  = '{1'b1, 4'd0, 32'h1000_0003, 32'h8012_3456, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 4'd0, 32'h1000_0001, 32'h1234_5678, 32'h0000_0056};
        vecs[3]  = '{1'b1, 4'd0, 32'h1000_0002, 32'h00F0_0000, 32'hFFFF_FFF0};
        vecs[4]  = '{1'b1, 4'd8, 32'h1000_0000, 32'h0000_00A5, 32'h0000_00A5};
        vecs[5]  = '{1'b1, 4'd1, 32'h1000_0002, 32'h8001_1234, 32'hFFFF_8001};
        vecs[6]  = '{1'b1, 4'd1, 32'h1000_0000, 32'h1234_7FFF, 32'h0000_7FFF};
        vecs[7]  = '{1'b1, 4'd9, 32'h1000_0000, 32'h0000_9ABC, 32'h0000_9ABC};
        vecs[8]  = '{1'b1, 4'd9, 32'h1000_0002, 32'hBEEF_0000, 32'h0000_BEEF};
        vecs[9]  = '{1'b1, 4'd5, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{1'b0, 4'd0, 32'h1234_5679, 32'hFFFF_FFFF, 32'h1234_5679};

        idle_inputs();
        exe_to_mem_zip  = '0;
        data_sram_rdata = '0;
        wb_allowin      = 1'b1;
        resetn          = 1'b0;
        #12;
        chk("rst_wb_valid", 32'(mem_to_wb_valid), 32'd0);
        chk("rst_full", 32'(mem_outstanding_full), 32'd0);
        chk("rst_allowin", 32'(mem_allowin), 32'd1);
        chk("rst_fwd", 32'(mem_rf_zip[38:37]), 32'd0);
        chk("rst_out_cnt", 32'(dut.out_cnt), 32'd0);
        chk("rst_cancel", 32'(dut.cancel_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Table: single-cycle loads (zero-latency response) and an ALU op.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_load) begin
                enter_load(vecs[i].op, vecs[i].alu, 32'h8000_0000 + 32'(i * 4));
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = vecs[i].rdata;
            end else begin
                @(negedge clk);
                exe_to_mem_valid = 1'b1;
                exe_to_mem_zip   = mk_zip(1'b0, vecs[i].alu, vecs[i].op, 32'h8000_0100, 1'b0, 1'b0);
                @(negedge clk);
                idle_inputs();
            end
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(mem_to_wb_valid), 32'd1);
            chk($sformatf("vec%0d_wdata", i), wb_wdata(), vecs[i].exp);
            chk($sformatf("vec%0d_fwd", i), mem_rf_zip[31:0], vecs[i].exp);
            chk($sformatf("vec%0d_stall", i), 32'(mem_rf_zip[38]), 32'd0);
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            chk($sformatf("vec%0d_out_cnt", i), 32'(dut.out_cnt), 32'd0);
        end
        chk("pc_field", mem_to_wb_zip[48:17], 32'h8000_0100);

        // Load with 3 cycles of latency.
        enter_load(4'd0, 32'h2000_0003, 32'h8000_0200);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("lat_stall%0d", c), 32'(mem_rf_zip[38]), 32'd1);
            chk($sformatf("lat_allowin%0d", c), 32'(mem_allowin), 32'd0);
            chk($sformatf("lat_valid%0d", c), 32'(mem_to_wb_valid), 32'd0);
            @(negedge clk);
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80AB_CDEF;
        #1;
        chk("lat_valid", 32'(mem_to_wb_valid), 32'd1);
        chk("lat_wdata", wb_wdata(), 32'hFFFF_FF80);
        chk("lat_stall_off", 32'(mem_rf_zip[38]), 32'd0);
        @(negedge clk);
        data_sram_data_ok = 1'b0;

        // WB back-pressure: response parked in the buffer.
        enter_load(4'd9, 32'h2000_0002, 32'h8000_0300);
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        #1;
        chk("bp_allowin0", 32'(mem_allowin), 32'd0);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("bp_buf_valid", 32'(dut.buf_valid), 32'd1);
        chk("bp_buf_wdata", wb_wdata(), 32'h0000_BEEF);
        @(negedge clk);
        wb_allowin = 1'b1;
        #1;
        chk("bp_valid", 32'(mem_to_wb_valid), 32'd1);
        chk("bp_wdata", wb_wdata(), 32'h0000_BEEF);
        chk("bp_allowin1", 32'(mem_allowin), 32'd1);
        @(negedge clk);
        chk("bp_buf_clr", 32'(dut.buf_valid), 32'd0);
        chk("bp_out_cnt", 32'(dut.out_cnt), 32'd0);

        // Flush with two requests in flight.
        enter_load(4'd2, 32'h3000_0000, 32'h8000_0400);
        data_sram_req     = 1'b1;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("fl_full", 32'(mem_outstanding_full), 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_valid_flush", 32'(mem_to_wb_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl_cancel2", 32'(dut.cancel_cnt), 32'd2);
        for (int d = 0; d < 2; d++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hDEAD_0000 + 32'(d);
            #1;
            chk($sformatf("fl_drop%0d_valid", d), 32'(mem_to_wb_valid), 32'd0);
            @(negedge clk);
            data_sram_data_ok = 1'b0;
        end
        chk("fl_cancel0", 32'(dut.cancel_cnt), 32'd0);
        chk("fl_out0", 32'(dut.out_cnt), 32'd0);
        enter_load(4'd2, 32'h3000_0004, 32'h8000_0410);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1357_9BDF;
        #1;
        chk("fl_post_valid", 32'(mem_to_wb_valid), 32'd1);
        chk("fl_post_wdata", wb_wdata(), 32'h1357_9BDF);
        @(negedge clk);
        data_sram_data_ok = 1'b0;

        // Full, concurrent accept/data_ok, saturation, async reset mid-wait.
        data_sram_req     = 1'b1;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("cc_full", 32'(mem_outstanding_full), 32'd1);
        data_sram_data_ok = 1'b1;
        @(negedge clk);
        chk("cc_same_cycle", 32'(dut.out_cnt), 32'd2);
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("cc_saturate", 32'(dut.out_cnt), 32'd2);
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
        exe_to_mem_valid  = 1'b1;
        exe_to_mem_zip    = mk_zip(1'b1, 32'h4000_0000, 4'd2, 32'h8000_0500, 1'b0, 1'b1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("cc_waiting", 32'(mem_rf_zip[38]), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("ar_out_cnt", 32'(dut.out_cnt), 32'd0);
        chk("ar_cancel", 32'(dut.cancel_cnt), 32'd0);
        chk("ar_valid", 32'(mem_to_wb_valid), 32'd0);
        chk("ar_full", 32'(mem_outstanding_full), 32'd0);
        chk("ar_allowin", 32'(mem_allowin), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
